regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 13 +
 rtl/mux2.sv | 13 +
 rtl/regfile.sv | 103 ++++++++++
 tb/tb_regfile.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state encoding for the register file.
package regfile_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/mux2.sv
// Two-input word multiplexer: y = sel ? b : a.
module mux2 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with x0 hardwired to zero, same-cycle write bypass
// and a one-register-per-cycle clear sweep.
module regfile #(
    parameter int unsigned WIDTH  = regfile_pkg::WIDTH,
    parameter int unsigned DEPTH  = regfile_pkg::DEPTH,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic [WIDTH-1:0]  wd,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    import regfile_pkg::state_e;
    import regfile_pkg::IDLE;
    import regfile_pkg::CLEAR;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_busy_q, clr_busy_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic wr_en_c;
    logic hit1_c;
    logic hit2_c;

    // A clear request in IDLE wins over a coincident write, so that write neither commits nor bypasses.
    assign wr_en_c = reset && we && (rd != '0) && (state_q == IDLE) && !clr_req;
    assign hit1_c  = wr_en_c && (rd == rs1);
    assign hit2_c  = wr_en_c && (rd == rs2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = ADDR_W'(1);
                end else if (wr_en_c) begin
                    mem_d[rd] = wd;
                end
            end
            CLEAR: begin
                mem_d[idx_q] = '0;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = ADDR_W'(1);
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = ADDR_W'(1);
            end
        endcase
        clr_busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= ADDR_W'(1);
            clr_busy_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_busy_q <= clr_busy_d;
            mem_q      <= mem_d;
        end
    end

    assign clr_busy = clr_busy_q;

    // Entry 0 is never written, so a plain array read already returns zero for x0.
    mux2 #(.WIDTH(WIDTH)) u_byp1 (
        .sel (hit1_c),
        .a   (mem_q[rs1]),
        .b   (wd),
        .y   (rd1)
    );

    mux2 #(.WIDTH(WIDTH)) u_byp2 (
        .sel (hit2_c),
        .a   (mem_q[rs2]),
        .b   (wd),
        .y   (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: a reference model predicts reads and clr_busy each cycle.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [63:0] wd;
    logic        clr_req;
    logic        clr_busy;
    logic [63:0] rd1, rd2;

    always #5 clk = ~clk;

    regfile #(.WIDTH(64), .DEPTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .we       (we),
        .wd       (wd),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .rd1      (rd1),
        .rd2      (rd2)
    );

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [63:0] m_mem [32];
    bit          m_busy;
    int          m_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
        if (reset && !m_busy && we && !clr_req && rd != 5'd0 && rd == rs) return wd;
        return m_mem[rs];
    endfunction

    // Reference behaviour at a rising edge, using the inputs held across that edge.
    task automatic model_edge();
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
            m_busy = 1'b0;
            m_idx  = 1;
        end else if (!m_busy) begin
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 1;
            end else if (we && rd != 5'd0) begin
                m_mem[rd] = wd;
            end
        end else begin
            m_mem[m_idx] = 64'd0;
            if (m_idx == 31) begin
                m_busy = 1'b0;
                m_idx  = 1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Push predictions for the current inputs, let the combinational paths settle, then score them.
    task automatic sample(input string tag);
        exp_t e;
        exp_q.push_back('{tag: {tag, ".rd1"}, port: 0, val: exp_read(rs1)});
        exp_q.push_back('{tag: {tag, ".rd2"}, port: 1, val: exp_read(rs2)});
        exp_q.push_back('{tag: {tag, ".busy"}, port: 2, val: 64'(m_busy)});
        #3;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.port)
                0:       check(e.tag, rd1, e.val);
                1:       check(e.tag, rd2, e.val);
                default: check(e.tag, 64'(clr_busy), e.val);
            endcase
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        we = 1'b1; rd = a; wd = d; rs1 = a; rs2 = 5'd0;
        sample($sformatf("wr%0d", a));
        tick();
        we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (clr_busy && n < 40) begin
            tick();
            n++;
        end
        if (clr_busy) check({tag, ".timeout"}, 64'd1, 64'd0);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        sample("clr_pulse");
        tick();
        clr_req = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b0; we = 1'b0; clr_req = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; wd = '0;
        tick();
        reset = 1'b1;

        rs1 = 5'd5; rs2 = 5'd31;
        sample("after_reset");

        we = 1'b1; rd = 5'd7; wd = 64'hDEAD_BEEF_0000_0001; rs2 = 5'd7; rs1 = 5'd5;
        sample("bypass7");
        tick();
        we = 1'b0;
        sample("stored7");
        check("x7_value", rd2, 64'hDEAD_BEEF_0000_0001);

        we = 1'b1; rd = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
        sample("wr_x0");
        tick();
        we = 1'b0;
        sample("x0_after");

        for (int i = 1; i < 32; i++) wr(5'(i), 64'(i));
        for (int i = 0; i < 8; i++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            sample("fill_rd");
        end

        // Sweep with a write at cycle 5 and a re-request at cycle 8, both to be ignored.
        pulse_clr();
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            we = (c == 5); rd = 5'd3; wd = 64'h123; clr_req = (c == 8);
            rs1 = 5'(c + 1); rs2 = 5'd3;
            sample($sformatf("sweep%0d", c));
            if (!clr_busy) break;
            busy_cnt++;
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        check("busy_len", 64'(busy_cnt), 64'd31);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            sample("post_clr");
        end

        // Reset partway through a sweep.
        for (int i = 1; i < 32; i++) wr(5'(i), ~64'(i));
        pulse_clr();
        for (int c = 0; c < 10; c++) begin
            rs1 = 5'(c + 1); rs2 = 5'(c + 15);
            sample("pre_abort");
            tick();
        end
        reset = 1'b0; we = 1'b1; rd = 5'd20; wd = 64'h55; clr_req = 1'b1;
        rs1 = 5'd20; rs2 = 5'd25;
        sample("abort_edge");
        tick();
        reset = 1'b1; we = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            sample("after_abort");
        end

        // A fresh sweep begins at x1: after one sweep edge x1 is cleared, x2 is not.
        wr(5'd1, 64'd11);
        wr(5'd2, 64'd22);
        rs1 = 5'd1; rs2 = 5'd2;
        pulse_clr();
        rs1 = 5'd1; rs2 = 5'd2;
        sample("restart0");
        tick();
        sample("restart1");
        check("restart_x2", rd2, 64'd22);
        wait_idle("restart");
        sample("restart_done");

        // Coincident clear request and write in IDLE.
        wr(5'd4, 64'd44);
        clr_req = 1'b1; we = 1'b1; rd = 5'd4; wd = 64'd9; rs1 = 5'd4; rs2 = 5'd4;
        sample("coinc");
        tick();
        clr_req = 1'b0; we = 1'b0;
        sample("coinc_next");
        check("coinc_x4", rd1, 64'd44);
        wait_idle("coinc");
        sample("coinc_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
